// File: rtl/sipo_pkg.sv
// Shared types and helpers for the serial-in, parallel-out receiver.
package sipo_pkg;

    // Receiver framing state: waiting for a start-of-frame, or collecting bits.
    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    // Width of the bit counter for a given word width. It never drops below
    // one bit, so the counter stays a legal vector for the smallest word.
    function automatic int cntWidth(input int dataWidth);
        return (dataWidth <= 2) ? 1 : $clog2(dataWidth);
    endfunction

endpackage

// File: rtl/sipo_out_reg.sv
// Single-entry valid/ready holding register for assembled words.
// A new word is taken when the register is empty or is being drained in the
// same cycle; otherwise the word is refused and an overrun pulse is raised.
module sipo_out_reg #(
    parameter int DATA_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  load_i,
    input  logic [DATA_WIDTH-1:0] load_data_i,
    input  logic                  ready_i,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic                  valid_o,
    output logic                  overrun_o
);

    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  valid_q, valid_d;
    logic                  accept;

    // Decide whether to take a new word, drain the held one, or hold.
    always_comb begin
        accept    = load_i && (!valid_q || ready_i);
        data_d    = data_q;
        valid_d   = valid_q;
        overrun_o = load_i && valid_q && !ready_i;
        if (accept) begin
            data_d  = load_data_i;
            valid_d = 1'b1;
        end else if (ready_i) begin
            valid_d = 1'b0;
        end
    end

    // Holding register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
        end
    end

    assign data_o  = data_q;
    assign valid_o = valid_q;

endmodule

// File: rtl/sipo_rx.sv
// Serial-in, parallel-out receiver. Rebuilds LSB-first words from a
// valid-qualified bit stream framed by a start-of-frame marker, hands each
// completed word to a valid/ready holding register and keeps sticky
// overrun and framing error flags.
module sipo_rx
    import sipo_pkg::*;
#(
    parameter int DATA_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  sin,
    input  logic                  sin_valid,
    input  logic                  sof,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  dout_valid,
    input  logic                  dout_ready,
    output logic                  overrun,
    output logic                  frame_err,
    input  logic                  err_clr
);

    localparam int CNT_W = cntWidth(DATA_WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    // Only the upper DATA_WIDTH-1 shift stages are kept: the stage that would
    // hold the oldest bit after a full word is replaced by the live input on
    // the completion cycle, so it never has to be stored.
    logic [DATA_WIDTH-2:0] sr_q, sr_d;
    logic                  overrun_q, overrun_d;
    logic                  frame_err_q, frame_err_d;

    logic [DATA_WIDTH-1:0] word;
    logic                  wordDone;
    logic                  frameErrSet;
    logic                  overrunPulse;

    // The word as it would look with the current bit shifted in at the MSB.
    assign word = {sin, sr_q};

    // Framing FSM, shifter and bit counter next-state logic.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        sr_d        = sr_q;
        wordDone    = 1'b0;
        frameErrSet = 1'b0;
        if (sin_valid) begin
            case (state_q)
                IDLE: begin
                    if (sof) begin
                        sr_d    = word[DATA_WIDTH-1:1];
                        cnt_d   = CNT_W'(1);
                        state_d = SHIFT;
                    end
                end
                SHIFT: begin
                    sr_d = word[DATA_WIDTH-1:1];
                    if (sof) begin
                        frameErrSet = 1'b1;
                        cnt_d       = CNT_W'(1);
                    end else if (cnt_q == LAST_BIT) begin
                        wordDone = 1'b1;
                        cnt_d    = '0;
                        state_d  = IDLE;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // Sticky error flags: a clear request drops them, a new error wins.
    always_comb begin
        overrun_d   = (overrun_q && !err_clr) || overrunPulse;
        frame_err_d = (frame_err_q && !err_clr) || frameErrSet;
    end

    // State, counter, shifter and flag registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            sr_q        <= '0;
            overrun_q   <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            sr_q        <= sr_d;
            overrun_q   <= overrun_d;
            frame_err_q <= frame_err_d;
        end
    end

    sipo_out_reg #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_out_reg (
        .clk        (clk),
        .resetn     (resetn),
        .load_i     (wordDone),
        .load_data_i(word),
        .ready_i    (dout_ready),
        .data_o     (dout),
        .valid_o    (dout_valid),
        .overrun_o  (overrunPulse)
    );

    assign overrun   = overrun_q;
    assign frame_err = frame_err_q;

endmodule

// File: tb/tb_sipo_rx.sv
// Self-checking bench for sipo_rx with a 4-bit word.
module tb_sipo_rx;

    localparam int W = 4;

    logic         clk;
    logic         resetn;
    logic         sin;
    logic         sin_valid;
    logic         sof;
    logic [W-1:0] dout;
    logic         dout_valid;
    logic         dout_ready;
    logic         overrun;
    logic         frame_err;
    logic         err_clr;

    int total;
    int bad;

    // Reference model state: bits collected for the current frame and the
    // word the consumer currently sees.
    bit           mBits[$];
    bit           mInFrame;
    logic [W-1:0] mDout;
    bit           mValid;
    bit           mOvr;
    bit           mFerr;

    typedef struct {
        bit           r;
        bit           s;
        bit           v;
        bit           f;
        bit           rd;
        bit           c;
        logic [W-1:0] eDout;
        bit           eValid;
        bit           eOvr;
        bit           eFerr;
    } vec_t;

    vec_t vecs[$];

    sipo_rx #(
        .DATA_WIDTH(W)
    ) dut (
        .clk       (clk),
        .resetn    (resetn),
        .sin       (sin),
        .sin_valid (sin_valid),
        .sof       (sof),
        .dout      (dout),
        .dout_valid(dout_valid),
        .dout_ready(dout_ready),
        .overrun   (overrun),
        .frame_err (frame_err),
        .err_clr   (err_clr)
    );

    // Free-running clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // One cycle of the receiver's rules, applied to the inputs of that cycle.
    task automatic modelStep(input bit r, input bit s, input bit v,
                             input bit f, input bit rd, input bit c);
        bit           done;
        bit           newOvr;
        bit           newFerr;
        logic [W-1:0] w;
        done    = 1'b0;
        newOvr  = 1'b0;
        newFerr = 1'b0;
        w       = '0;
        if (!r) begin
            mBits.delete();
            mInFrame = 1'b0;
            mDout    = '0;
            mValid   = 1'b0;
            mOvr     = 1'b0;
            mFerr    = 1'b0;
            return;
        end
        if (v) begin
            if (f) begin
                if (mInFrame) newFerr = 1'b1;
                mBits.delete();
                mBits.push_back(s);
                mInFrame = 1'b1;
            end else if (mInFrame) begin
                mBits.push_back(s);
            end
            if (mInFrame && mBits.size() == W) begin
                for (int i = 0; i < W; i++) w[i] = mBits[i];
                done     = 1'b1;
                mInFrame = 1'b0;
                mBits.delete();
            end
        end
        if (done) begin
            if (!mValid || rd) begin
                mDout  = w;
                mValid = 1'b1;
            end else begin
                newOvr = 1'b1;
            end
        end else if (mValid && rd) begin
            mValid = 1'b0;
        end
        mOvr  = (mOvr && !c) || newOvr;
        mFerr = (mFerr && !c) || newFerr;
    endtask

    // Drive one cycle of inputs, advance the model and step past the edge.
    task automatic applyStimulus(input bit r, input bit s, input bit v,
                                 input bit f, input bit rd, input bit c);
        resetn     = r;
        sin        = s;
        sin_valid  = v;
        sof        = f;
        dout_ready = rd;
        err_clr    = c;
        modelStep(r, s, v, f, rd, c);
        @(posedge clk);
        #1;
    endtask

    task automatic checkVal(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic checkOutput(input string name, input logic [W-1:0] eDout,
                               input bit eValid, input bit eOvr, input bit eFerr);
        checkVal({name, ".dout"}, int'(dout), int'(eDout));
        checkVal({name, ".dout_valid"}, int'(dout_valid), int'(eValid));
        checkVal({name, ".overrun"}, int'(overrun), int'(eOvr));
        checkVal({name, ".frame_err"}, int'(frame_err), int'(eFerr));
    endtask

    task automatic checkModel(input string name);
        checkOutput(name, mDout, mValid, mOvr, mFerr);
    endtask

    // One full word, sof on bit 0, ready per bit taken from rdMask.
    task automatic sendWord(input string name, input logic [W-1:0] w,
                            input logic [W-1:0] rdMask);
        logic [W-1:0] wv;
        logic [W-1:0] rv;
        wv = w;
        rv = rdMask;
        for (int i = 0; i < W; i++) begin
            applyStimulus(1'b1, wv[i], 1'b1, (i == 0), rv[i], 1'b0);
            checkModel(name);
        end
    endtask

    function automatic vec_t mk(input bit r, input bit s, input bit v, input bit f,
                                input bit rd, input bit c, input logic [W-1:0] eDout,
                                input bit eValid, input bit eOvr, input bit eFerr);
        vec_t t;
        t.r = r; t.s = s; t.v = v; t.f = f; t.rd = rd; t.c = c;
        t.eDout = eDout; t.eValid = eValid; t.eOvr = eOvr; t.eFerr = eFerr;
        return t;
    endfunction

    initial begin
        total = 0;
        bad   = 0;
        resetn = 1'b0; sin = 1'b0; sin_valid = 1'b0; sof = 1'b0;
        dout_ready = 1'b0; err_clr = 1'b0;
        mDout = '0;

        // Reset, basic word 4'hA, gapped word 4'h3, stray bits while idle.
        vecs.push_back(mk(0,0,0,0,0,0, 4'h0,0,0,0));
        vecs.push_back(mk(0,1,1,1,1,0, 4'h0,0,0,0));
        vecs.push_back(mk(1,0,1,1,1,0, 4'h0,0,0,0));
        vecs.push_back(mk(1,1,1,0,1,0, 4'h0,0,0,0));
        vecs.push_back(mk(1,0,1,0,1,0, 4'h0,0,0,0));
        vecs.push_back(mk(1,1,1,0,1,0, 4'hA,1,0,0));
        vecs.push_back(mk(1,0,0,0,1,0, 4'hA,0,0,0));
        vecs.push_back(mk(1,0,0,0,1,0, 4'hA,0,0,0));
        vecs.push_back(mk(1,1,1,1,0,0, 4'hA,0,0,0));
        vecs.push_back(mk(1,0,0,0,0,0, 4'hA,0,0,0));
        vecs.push_back(mk(1,0,0,1,0,0, 4'hA,0,0,0));
        vecs.push_back(mk(1,1,1,0,0,0, 4'hA,0,0,0));
        vecs.push_back(mk(1,1,0,0,0,0, 4'hA,0,0,0));
        vecs.push_back(mk(1,0,0,1,0,0, 4'hA,0,0,0));
        vecs.push_back(mk(1,0,1,0,0,0, 4'hA,0,0,0));
        vecs.push_back(mk(1,0,0,0,0,0, 4'hA,0,0,0));
        vecs.push_back(mk(1,1,0,0,0,0, 4'hA,0,0,0));
        vecs.push_back(mk(1,0,1,0,0,0, 4'h3,1,0,0));
        vecs.push_back(mk(1,0,0,0,0,0, 4'h3,1,0,0));
        vecs.push_back(mk(1,0,0,0,1,0, 4'h3,0,0,0));
        vecs.push_back(mk(1,1,1,0,1,0, 4'h3,0,0,0));
        vecs.push_back(mk(1,1,1,0,1,0, 4'h3,0,0,0));

        foreach (vecs[i]) begin
            applyStimulus(vecs[i].r, vecs[i].s, vecs[i].v, vecs[i].f,
                          vecs[i].rd, vecs[i].c);
            checkOutput($sformatf("vec%0d", i), vecs[i].eDout, vecs[i].eValid,
                        vecs[i].eOvr, vecs[i].eFerr);
            checkModel($sformatf("vec%0d.model", i));
        end

        // Backpressure: 4'h5 held, 4'hC dropped, then a single transfer.
        sendWord("bp5", 4'h5, 4'b0000);
        sendWord("bpC", 4'hC, 4'b0000);
        checkOutput("overrun_set", 4'h5, 1, 1, 0);
        applyStimulus(1, 0, 0, 0, 1, 0);
        checkOutput("bp_drain", 4'h5, 0, 1, 0);
        applyStimulus(1, 0, 0, 0, 1, 0);
        checkOutput("bp_once", 4'h5, 0, 1, 0);
        applyStimulus(1, 0, 0, 0, 0, 1);
        checkOutput("ovr_clr", 4'h5, 0, 0, 0);

        // Consume-and-load in the same cycle keeps valid high without a bubble.
        sendWord("hold9", 4'h9, 4'b0000);
        applyStimulus(1, 0, 0, 0, 0, 0);
        checkOutput("hold9_wait", 4'h9, 1, 0, 0);
        sendWord("swap6", 4'h6, 4'b1000);
        checkOutput("swap6_done", 4'h6, 1, 0, 0);
        applyStimulus(1, 0, 0, 0, 1, 0);
        checkOutput("swap6_drain", 4'h6, 0, 0, 0);

        // Back-to-back frames are legal and raise no framing error.
        sendWord("b2bA", 4'hA, 4'b1111);
        sendWord("b2b5", 4'h5, 4'b1111);
        checkOutput("b2b_done", 4'h5, 1, 0, 0);

        // Early sof: the fragment is discarded and the restarted word lands.
        applyStimulus(1, 0, 1, 1, 1, 0);
        checkModel("frag0");
        applyStimulus(1, 1, 1, 0, 1, 0);
        checkModel("frag1");
        sendWord("earlyF", 4'hF, 4'b1111);
        checkOutput("early_done", 4'hF, 1, 0, 1);
        applyStimulus(1, 0, 0, 0, 1, 0);
        checkOutput("early_drain", 4'hF, 0, 0, 1);

        // Clear and a new framing error in the same cycle: the set wins.
        applyStimulus(1, 1, 1, 1, 1, 0);
        applyStimulus(1, 1, 1, 1, 1, 1);
        checkOutput("set_wins", 4'hF, 0, 0, 1);
        applyStimulus(1, 0, 0, 0, 1, 1);
        checkOutput("ferr_clr", 4'hF, 0, 0, 0);

        // Reset mid-word discards the partial word and the held output.
        applyStimulus(1, 1, 1, 1, 1, 0);
        applyStimulus(1, 1, 1, 0, 1, 0);
        applyStimulus(0, 1, 1, 0, 1, 0);
        checkOutput("mid_reset", 4'h0, 0, 0, 0);
        applyStimulus(1, 1, 1, 0, 1, 0);
        applyStimulus(1, 1, 1, 0, 1, 0);
        checkOutput("post_reset_idle", 4'h0, 0, 0, 0);
        sendWord("after8", 4'h8, 4'b1111);
        checkOutput("after8_done", 4'h8, 1, 0, 0);

        // Random traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            applyStimulus(($urandom_range(0, 299) != 0),
                          1'($urandom_range(0, 1)),
                          ($urandom_range(0, 3) != 0),
                          ($urandom_range(0, 5) == 0),
                          1'($urandom_range(0, 1)),
                          ($urandom_range(0, 15) == 0));
            checkModel($sformatf("rand%0d", n));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
